count_wrap_monitor: RTL and testbench
=====================================

COUNT_WRAP_MONITOR -- requirements
Module: count_wrap_monitor

Interface
REQ-001 Parameter WRAP_W, default 8, width of wrap_count.
REQ-002 Parameter STABLE_CYCLES, default 2, range 1..7; consecutive identical samples required to accept a count.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 q_in  input  4  count from the upstream 4-bit ripple counter, asynchronous to clk.
REQ-006 enable  input  1  high = monitor tracks q_in; low = all state frozen.
REQ-007 clear  input  1  one-cycle request clearing wrap_count and sticky flags.
REQ-008 out_ready  input  1  downstream accepts count_out.
REQ-009 out_valid  output  1  count_out holds an accepted, unconsumed count.
REQ-010 count_out  output  4  last accepted stable count.
REQ-011 wrap_pulse  output  1  one-cycle pulse on an accepted 15->0 transition.
REQ-012 wrap_count  output  WRAP_W  saturating count of wraps.
REQ-013 overflow  output  1  sticky; a wrap occurred while wrap_count was saturated.
REQ-014 reset_seen  output  1  one-cycle pulse on an accepted jump to 0 from 1..14.
REQ-015 err_skip  output  1  sticky; any other accepted transition not equal to +1 mod 16.
REQ-016 dropped  output  1  sticky; an unconsumed count was overwritten.

Function
REQ-017 q_in SHALL pass through a two-flop synchronizer before any use.
REQ-018 A synchronized value SHALL be accepted when it has been equal for STABLE_CYCLES consecutive enabled cycles and differs from the last accepted value; a stable input change is accepted STABLE_CYCLES+2 cycles after q_in changes.
REQ-019 FSM states: INIT, TRACK.
REQ-020 INIT: first accepted value sets the baseline, sets out_valid and count_out, raises no event; transition to TRACK.
REQ-021 TRACK, accepted new value N, previous P: N==P+1 mod 16 with P!=15 -> step, no event.
REQ-022 TRACK, P==15 and N==0: wrap_pulse high one cycle; wrap_count+1, or unchanged with overflow set if already all ones.
REQ-023 TRACK, N==0 and P in 1..14: reset_seen high one cycle; wrap_count unchanged.
REQ-024 TRACK, any other N: err_skip set; count_out updated.
REQ-025 Every acceptance SHALL load count_out and set out_valid on the next cycle.
REQ-026 out_valid SHALL clear on a cycle with out_valid and out_ready high, unless an acceptance occurs in that cycle, in which case out_valid stays high with the new count.
REQ-027 An acceptance while out_valid high and out_ready low SHALL overwrite count_out and set dropped.
REQ-028 enable low: filter, FSM, and outputs hold; pulses forced low; the out_valid/out_ready handshake still completes.
REQ-029 clear SHALL zero wrap_count, overflow, err_skip, and dropped next cycle; if a wrap is accepted in the same cycle, wrap_count becomes 1.
REQ-030 Event pulses SHALL never be asserted in consecutive cycles for the same acceptance.

Reset
REQ-031 reset high at a rising edge: FSM to INIT; synchronizer, filter, and all outputs to 0 (count_out 0, wrap_count 0, flags 0).
REQ-032 reset SHALL override enable, clear, and any in-flight acceptance; reset mid-handshake drops the pending count without setting dropped.

Structure
REQ-033 Shared package count_mon_pkg SHALL hold the FSM state enum, count width 4, and the maximum value 4'd15.
REQ-034 Synchronizer and stability filter SHALL form sub-module sync_stable_filter (outputs stable value and accept strobe).

Verification
REQ-035 Reset, then q_in 0..15..0 with 20-cycle steps, out_ready=1 -> 16 steps, wrap_pulse once, wrap_count=1, no flags.
REQ-036 Glitch: q_in 3->7->4 with 7 held 1 cycle (STABLE_CYCLES=2) -> 7 never accepted, 3->4 step, err_skip=0.
REQ-037 Preload wrap_count=255 via 255 wraps, one more wrap -> wrap_count stays 255, overflow=1.
REQ-038 q_in 0..9 then 0 -> reset_seen pulse, wrap_count unchanged; then jump 0->5 -> err_skip=1.
REQ-039 out_ready=0 across two acceptances (5,6) -> count_out=6, dropped=1; out_ready=1 -> out_valid clears next cycle.
REQ-040 reset asserted mid-count with out_valid=1 -> next cycle all outputs 0, FSM INIT, next accepted value raises no event.

Source files
------------

// File: rtl/count_mon_pkg.sv
// Shared types and constants for the count wrap monitor: the 4-bit count
// type, its maximum value, the FSM state enum and the transition classifier.
package count_mon_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = 4'd15;

  typedef enum logic {
    ST_INIT,
    ST_TRACK
  } state_t;

  typedef enum logic [1:0] {
    EV_STEP,
    EV_WRAP,
    EV_RESET,
    EV_SKIP
  } event_t;

  // Classify an accepted transition from prevVal to nextVal. The two values
  // always differ when this is used, so 0 -> 0 never reaches the reset case.
  function automatic event_t classify(input cnt_t prevVal, input cnt_t nextVal);
    event_t ev;
    if (prevVal == CNT_MAX && nextVal == '0) begin
      ev = EV_WRAP;
    end else if (nextVal == cnt_t'(prevVal + 1'b1)) begin
      ev = EV_STEP;
    end else if (nextVal == '0) begin
      ev = EV_RESET;
    end else begin
      ev = EV_SKIP;
    end
    return ev;
  endfunction

endpackage

// File: rtl/count_wrap_monitor_if.sv
// Output handshake of the monitor: the accepted count with a valid/ready pair.
interface count_wrap_monitor_if;
  import count_mon_pkg::*;

  logic out_valid;
  logic out_ready;
  cnt_t count_out;

  modport master (
    output out_valid,
    output count_out,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  count_out,
    output out_ready
  );

endinterface

// File: rtl/sync_stable_filter.sv
// Two-flop synchronizer followed by a stability filter. A value is accepted
// once the synchronized input has matched it on STABLE_CYCLES consecutive
// enabled edges and it differs from the previously accepted value (the very
// first stable value after reset is always accepted). accept_o is a one-cycle
// strobe; stable_o holds the last accepted value.
module sync_stable_filter
  import count_mon_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  input  cnt_t q_i,
  output cnt_t stable_o,
  output logic accept_o
);

  localparam logic [2:0] RUN_MAX = 3'(STABLE_CYCLES);

  cnt_t       sync1_q, sync2_q;
  cnt_t       cand_q, cand_d;
  logic [2:0] run_q, run_d;
  cnt_t       acc_q, acc_d;
  logic       accValid_q, accValid_d;
  logic       accept_q, accept_d;
  logic [2:0] runNext;

  // Synchronizer flops run every cycle so the sampled value is always fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= q_i;
      sync2_q <= sync1_q;
    end
  end

  // Run length of the current candidate, restarting at 1 on any change and
  // saturating at the required length; accept when the run first completes
  // for a value not yet accepted.
  always_comb begin
    cand_d     = cand_q;
    run_d      = run_q;
    acc_d      = acc_q;
    accValid_d = accValid_q;
    accept_d   = 1'b0;
    runNext    = 3'd1;
    if (sync2_q == cand_q) begin
      runNext = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 3'd1;
    end
    if (enable_i) begin
      cand_d = sync2_q;
      run_d  = runNext;
      if (runNext == RUN_MAX && (!accValid_q || sync2_q != acc_q)) begin
        accept_d   = 1'b1;
        acc_d      = sync2_q;
        accValid_d = 1'b1;
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q     <= '0;
      run_q      <= '0;
      acc_q      <= '0;
      accValid_q <= 1'b0;
      accept_q   <= 1'b0;
    end else begin
      cand_q     <= cand_d;
      run_q      <= run_d;
      acc_q      <= acc_d;
      accValid_q <= accValid_d;
      accept_q   <= accept_d;
    end
  end

  assign stable_o = acc_q;
  assign accept_o = accept_q;

endmodule

// File: rtl/count_wrap_monitor.sv
// Monitors an asynchronous 4-bit ripple counter: filters its value, tracks
// accepted transitions, counts wraps (saturating), flags resets, skips and
// dropped outputs, and offers each accepted count over a valid/ready port.
module count_wrap_monitor
  import count_mon_pkg::*;
#(
  parameter int WRAP_W        = 8,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  cnt_t                    q_in,
  input  logic                    enable,
  input  logic                    clear,
  count_wrap_monitor_if.master    out_bus,
  output logic                    wrap_pulse,
  output logic [WRAP_W-1:0]       wrap_count,
  output logic                    overflow,
  output logic                    reset_seen,
  output logic                    err_skip,
  output logic                    dropped
);

  state_t            state_q, state_d;
  cnt_t              countOut_q, countOut_d;
  logic              outValid_q, outValid_d;
  logic              wrapPulse_q, wrapPulse_d;
  logic              resetSeen_q, resetSeen_d;
  logic [WRAP_W-1:0] wrapCount_q, wrapCount_d;
  logic              overflow_q, overflow_d;
  logic              errSkip_q, errSkip_d;
  logic              dropped_q, dropped_d;

  cnt_t   stableVal;
  logic   acceptRaw;
  logic   accept;
  logic   clearEn;
  event_t ev;

  sync_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk     (clk),
    .reset   (reset),
    .enable_i(enable),
    .q_i     (q_in),
    .stable_o(stableVal),
    .accept_o(acceptRaw)
  );

  assign accept  = acceptRaw & enable;
  assign clearEn = clear & enable;
  assign ev      = classify(countOut_q, stableVal);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // The first acceptance sets the baseline and moves to tracking.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && accept) begin
      state_d = ST_TRACK;
    end
  end

  // Output and flag update: load every acceptance, classify it while
  // tracking, complete the handshake independently of enable, and let clear
  // win over any flag set in the same cycle except a simultaneous wrap.
  always_comb begin
    countOut_d  = countOut_q;
    outValid_d  = outValid_q;
    wrapPulse_d = 1'b0;
    resetSeen_d = 1'b0;
    wrapCount_d = wrapCount_q;
    overflow_d  = overflow_q;
    errSkip_d   = errSkip_q;
    dropped_d   = dropped_q;

    if (accept) begin
      countOut_d = stableVal;
      outValid_d = 1'b1;
      if (outValid_q && !out_bus.out_ready) begin
        dropped_d = 1'b1;
      end
    end else if (outValid_q && out_bus.out_ready) begin
      outValid_d = 1'b0;
    end

    if (accept && state_q == ST_TRACK) begin
      case (ev)
        EV_WRAP: begin
          wrapPulse_d = 1'b1;
          if (wrapCount_q == {WRAP_W{1'b1}}) begin
            overflow_d = 1'b1;
          end else begin
            wrapCount_d = wrapCount_q + WRAP_W'(1);
          end
        end
        EV_RESET: resetSeen_d = 1'b1;
        EV_SKIP:  errSkip_d   = 1'b1;
        default:  ;
      endcase
    end

    if (clearEn) begin
      wrapCount_d = (accept && state_q == ST_TRACK && ev == EV_WRAP)
                    ? WRAP_W'(1) : '0;
      overflow_d  = 1'b0;
      errSkip_d   = 1'b0;
      dropped_d   = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      countOut_q  <= '0;
      outValid_q  <= 1'b0;
      wrapPulse_q <= 1'b0;
      resetSeen_q <= 1'b0;
      wrapCount_q <= '0;
      overflow_q  <= 1'b0;
      errSkip_q   <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      countOut_q  <= countOut_d;
      outValid_q  <= outValid_d;
      wrapPulse_q <= wrapPulse_d;
      resetSeen_q <= resetSeen_d;
      wrapCount_q <= wrapCount_d;
      overflow_q  <= overflow_d;
      errSkip_q   <= errSkip_d;
      dropped_q   <= dropped_d;
    end
  end

  assign out_bus.out_valid = outValid_q;
  assign out_bus.count_out = countOut_q;
  assign wrap_pulse        = wrapPulse_q;
  assign reset_seen        = resetSeen_q;
  assign wrap_count        = wrapCount_q;
  assign overflow          = overflow_q;
  assign err_skip          = errSkip_q;
  assign dropped           = dropped_q;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed bench for count_wrap_monitor with STABLE_CYCLES=2, WRAP_W=8.
module tb_count_wrap_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] q_in;
  logic       enable;
  logic       clear;
  logic       wrap_pulse;
  logic [7:0] wrap_count;
  logic       overflow;
  logic       reset_seen;
  logic       err_skip;
  logic       dropped;

  int checks = 0;
  int passes = 0;

  int         changeCnt = 0;
  int         wrapCnt   = 0;
  int         rsCnt     = 0;
  logic       sawSeven  = 1'b0;
  logic [3:0] lastCount = 4'd0;

  count_wrap_monitor_if bus ();

  count_wrap_monitor #(
    .WRAP_W       (8),
    .STABLE_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .q_in      (q_in),
    .enable    (enable),
    .clear     (clear),
    .out_bus   (bus),
    .wrap_pulse(wrap_pulse),
    .wrap_count(wrap_count),
    .overflow  (overflow),
    .reset_seen(reset_seen),
    .err_skip  (err_skip),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  // Event observer sampling on the falling edge.
  always @(negedge clk) begin
    if (bus.count_out !== lastCount) changeCnt++;
    lastCount = bus.count_out;
    if (wrap_pulse === 1'b1) wrapCnt++;
    if (reset_seen === 1'b1) rsCnt++;
    if (bus.count_out === 4'd7) sawSeven = 1'b1;
  end

  task automatic clearCounters();
    changeCnt = 0;
    wrapCnt   = 0;
    rsCnt     = 0;
    sawSeven  = 1'b0;
    lastCount = bus.count_out;
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    q_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    q_in = 4'd0;
    enable = 1'b1;
    clear = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    clearCounters();
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %0d expected 0", bus.out_valid); else passes++;
    checks++; if (bus.count_out !== 4'd0) $display("[TB] FAIL reset_count_out: got %0d expected 0", bus.count_out); else passes++;
    checks++; if (wrap_count !== 8'd0) $display("[TB] FAIL reset_wrap_count: got %0d expected 0", wrap_count); else passes++;
    checks++; if ({wrap_pulse, reset_seen, overflow, err_skip, dropped} !== 5'b0)
      $display("[TB] FAIL reset_flags: got %b expected 00000", {wrap_pulse, reset_seen, overflow, err_skip, dropped});
    else passes++;
  endtask

  task automatic test_latency();
    doReset();
    hold(4'd0, 8);
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL baseline_consumed: got %0d expected 0", bus.out_valid); else passes++;
    q_in = 4'd1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (bus.count_out !== 4'd0) $display("[TB] FAIL latency_early: got %0d expected 0", bus.count_out); else passes++;
    @(posedge clk);
    #1;
    checks++; if (bus.count_out !== 4'd1) $display("[TB] FAIL latency_load: got %0d expected 1", bus.count_out); else passes++;
    checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL latency_valid: got %0d expected 1", bus.out_valid); else passes++;
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL latency_consume: got %0d expected 0", bus.out_valid); else passes++;
  endtask

  task automatic test_count_sequence();
    doReset();
    for (int v = 0; v < 16; v++) hold(4'(v), 20);
    hold(4'd0, 20);
    checks++; if (changeCnt != 16) $display("[TB] FAIL seq_steps: got %0d expected 16", changeCnt); else passes++;
    checks++; if (wrapCnt != 1) $display("[TB] FAIL seq_wrap_pulses: got %0d expected 1", wrapCnt); else passes++;
    checks++; if (wrap_count !== 8'd1) $display("[TB] FAIL seq_wrap_count: got %0d expected 1", wrap_count); else passes++;
    checks++; if (rsCnt != 0) $display("[TB] FAIL seq_reset_seen: got %0d expected 0", rsCnt); else passes++;
    checks++; if ({overflow, err_skip, dropped} !== 3'b0)
      $display("[TB] FAIL seq_flags: got %b expected 000", {overflow, err_skip, dropped});
    else passes++;
  endtask

  task automatic test_glitch();
    doReset();
    for (int v = 0; v < 4; v++) hold(4'(v), 8);
    clearCounters();
    q_in = 4'd7;
    @(posedge clk);
    #1;
    hold(4'd4, 10);
    checks++; if (changeCnt != 1) $display("[TB] FAIL glitch_changes: got %0d expected 1", changeCnt); else passes++;
    checks++; if (bus.count_out !== 4'd4) $display("[TB] FAIL glitch_count: got %0d expected 4", bus.count_out); else passes++;
    checks++; if (sawSeven !== 1'b0) $display("[TB] FAIL glitch_seven_seen: got %0d expected 0", sawSeven); else passes++;
    checks++; if (err_skip !== 1'b0) $display("[TB] FAIL glitch_err_skip: got %0d expected 0", err_skip); else passes++;
  endtask

  task automatic test_reset_seen();
    doReset();
    for (int v = 0; v < 10; v++) hold(4'(v), 8);
    hold(4'd0, 10);
    checks++; if (rsCnt != 1) $display("[TB] FAIL rs_pulses: got %0d expected 1", rsCnt); else passes++;
    checks++; if (wrap_count !== 8'd0) $display("[TB] FAIL rs_wrap_count: got %0d expected 0", wrap_count); else passes++;
    checks++; if (err_skip !== 1'b0) $display("[TB] FAIL rs_err_skip: got %0d expected 0", err_skip); else passes++;
    hold(4'd5, 10);
    checks++; if (err_skip !== 1'b1) $display("[TB] FAIL skip_err_skip: got %0d expected 1", err_skip); else passes++;
    checks++; if (rsCnt != 1) $display("[TB] FAIL skip_no_reset_seen: got %0d expected 1", rsCnt); else passes++;
  endtask

  task automatic test_backpressure();
    doReset();
    hold(4'd0, 8);
    bus.out_ready = 1'b0;
    hold(4'd5, 8);
    checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL bp_valid_first: got %0d expected 1", bus.out_valid); else passes++;
    checks++; if (dropped !== 1'b0) $display("[TB] FAIL bp_dropped_first: got %0d expected 0", dropped); else passes++;
    hold(4'd6, 8);
    checks++; if (bus.count_out !== 4'd6) $display("[TB] FAIL bp_count: got %0d expected 6", bus.count_out); else passes++;
    checks++; if (dropped !== 1'b1) $display("[TB] FAIL bp_dropped: got %0d expected 1", dropped); else passes++;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL bp_consume: got %0d expected 0", bus.out_valid); else passes++;
  endtask

  task automatic test_enable();
    doReset();
    hold(4'd0, 8);
    hold(4'd1, 8);
    enable = 1'b0;
    hold(4'd2, 12);
    checks++; if (bus.count_out !== 4'd1) $display("[TB] FAIL en_frozen: got %0d expected 1", bus.count_out); else passes++;
    enable = 1'b1;
    hold(4'd2, 10);
    checks++; if (bus.count_out !== 4'd2) $display("[TB] FAIL en_resume: got %0d expected 2", bus.count_out); else passes++;
    checks++; if (err_skip !== 1'b0) $display("[TB] FAIL en_err_skip: got %0d expected 0", err_skip); else passes++;
  endtask

  task automatic test_overflow_clear();
    doReset();
    hold(4'd0, 8);
    for (int i = 0; i < 255; i++) begin
      hold(4'd15, 6);
      hold(4'd0, 6);
    end
    checks++; if (wrap_count !== 8'd255) $display("[TB] FAIL ovf_preload: got %0d expected 255", wrap_count); else passes++;
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL ovf_not_yet: got %0d expected 0", overflow); else passes++;
    hold(4'd15, 6);
    hold(4'd0, 6);
    checks++; if (wrap_count !== 8'd255) $display("[TB] FAIL ovf_saturate: got %0d expected 255", wrap_count); else passes++;
    checks++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_set: got %0d expected 1", overflow); else passes++;
    checks++; if (wrapCnt != 256) $display("[TB] FAIL ovf_pulses: got %0d expected 256", wrapCnt); else passes++;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    checks++; if ({wrap_count, overflow, err_skip, dropped} !== 11'd0)
      $display("[TB] FAIL clear_all: got %b expected 0", {wrap_count, overflow, err_skip, dropped});
    else passes++;
    hold(4'd15, 6);
    q_in = 4'd0;
    repeat (4) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    checks++; if (wrap_count !== 8'd1) $display("[TB] FAIL clear_with_wrap: got %0d expected 1", wrap_count); else passes++;
    checks++; if (err_skip !== 1'b0) $display("[TB] FAIL clear_err_skip: got %0d expected 0", err_skip); else passes++;
  endtask

  task automatic test_reset_mid();
    doReset();
    bus.out_ready = 1'b0;
    hold(4'd0, 8);
    hold(4'd1, 8);
    checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL mid_pending: got %0d expected 1", bus.out_valid); else passes++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if ({bus.out_valid, bus.count_out, dropped, err_skip, wrap_count} !== 15'd0)
      $display("[TB] FAIL mid_reset_clears: got %b expected 0", {bus.out_valid, bus.count_out, dropped, err_skip, wrap_count});
    else passes++;
    clearCounters();
    hold(4'd1, 12);
    checks++; if (bus.count_out !== 4'd1) $display("[TB] FAIL mid_reaccept: got %0d expected 1", bus.count_out); else passes++;
    checks++; if (wrapCnt + rsCnt != 0) $display("[TB] FAIL mid_no_event: got %0d expected 0", wrapCnt + rsCnt); else passes++;
    checks++; if (err_skip !== 1'b0) $display("[TB] FAIL mid_err_skip: got %0d expected 0", err_skip); else passes++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_count_sequence();
    test_glitch();
    test_reset_seen();
    test_backpressure();
    test_enable();
    test_overflow_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
